// File: rtl/band_sample_scheduler_pkg.sv
// light_music_pkg: sample format and scheduler state shared by the light-music blocks.
package light_music_pkg;
   localparam int SAMPLE_W = 12;
   localparam logic [SAMPLE_W-1:0] SAMPLE_OFFSET = 12'h800;
   typedef enum logic {IDLE, SEND} sched_state_t;
endpackage

// File: rtl/band_sample_scheduler_if.sv
// band_sample_scheduler_if: valid/ready sample stream from the scheduler to the light driver.
interface band_sample_scheduler_if import light_music_pkg::*; #(parameter int NBANDS = 8);
   localparam int BW = $clog2(NBANDS);
   logic out_valid;
   logic out_ready;
   logic frame_start;
   logic [SAMPLE_W-1:0] out_data;
   logic [BW-1:0] out_band;
   modport master (output out_valid, out_data, out_band, frame_start, input out_ready);
   modport slave (input out_valid, out_data, out_band, frame_start, output out_ready);
endinterface

// File: rtl/band_sample_scheduler_decim_tick_gen.sv
// decim_tick_gen: counts ADC strobes and flags every DECIM-th one as a decimated tick.
module decim_tick_gen #(parameter int DECIM = 16) (
   input  logic clk,
   input  logic nreset,
   input  logic sample_en,
   output logic tick
);
   localparam int CW = $clog2(DECIM);
   logic [CW-1:0] count;
   assign tick = sample_en && count == CW'(DECIM - 1);
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) count <= '0;
      else if (sample_en) count <= tick ? '0 : count + 1'b1;
endmodule

// File: rtl/band_sample_scheduler.sv
// band_sample_scheduler: snapshots all band accumulators per decimated tick and streams them
// as 12-bit offset-binary samples; BAND_SATURATE_EN selects saturating instead of wrapping conversion.
module band_sample_scheduler import light_music_pkg::*; #(
   parameter int NBANDS  = 8,
   parameter int DW      = 48,
   parameter int RANGE_H = 28,
   parameter int DECIM   = 16
) (
   input  logic                   clk,
   input  logic                   nreset,
   input  logic                   sample_en,
   input  logic [NBANDS*DW-1:0]   band_data,
   band_sample_scheduler_if.master stream,
   output logic                   overrun
);
   localparam int BW = $clog2(NBANDS);
   sched_state_t state, state_nx;
   logic [DW-1:0] snap [NBANDS];
   logic [BW-1:0] idx, idx_nx;
   logic tick, hs, last;
   decim_tick_gen #(.DECIM(DECIM)) u_tick (.clk(clk), .nreset(nreset), .sample_en(sample_en), .tick(tick));
   function automatic logic [SAMPLE_W-1:0] conv(input logic [DW-1:0] x);
`ifdef BAND_SATURATE_EN
      logic [DW-RANGE_H-1:0] hi;
      hi = x[DW-1:RANGE_H];
      return (&hi || ~|hi) ? x[RANGE_H -: SAMPLE_W] + SAMPLE_OFFSET : (x[DW-1] ? '0 : '1);
`else
      return x[RANGE_H -: SAMPLE_W] + SAMPLE_OFFSET;
`endif
   endfunction
   assign hs   = state == SEND && stream.out_ready;
   assign last = idx == BW'(NBANDS - 1);
   always_comb begin
      state_nx = state == IDLE ? (tick ? SEND : IDLE) : (hs && last ? IDLE : SEND);
      idx_nx   = (hs && !last) ? idx + 1'b1 : ((hs || state == IDLE) ? '0 : idx);
   end
   // idx rests at 0 in IDLE, so out_band and frame_start need no extra gating there
   assign stream.out_valid   = state == SEND;
   assign stream.out_band    = idx;
   assign stream.out_data    = state == SEND ? conv(snap[idx]) : '0;
   assign stream.frame_start = state == SEND && idx == '0;
   always_ff @(posedge clk or negedge nreset)
      if (!nreset) begin
         state   <= IDLE;
         idx     <= '0;
         overrun <= 1'b0;
         for (int i = 0; i < NBANDS; i++) snap[i] <= '0;
      end else begin
         state   <= state_nx;
         idx     <= idx_nx;
         overrun <= tick && state == SEND;
         if (state == IDLE && tick)
            for (int i = 0; i < NBANDS; i++) snap[i] <= band_data[i*DW +: DW];
      end
endmodule
